// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
//   sar_state_e   - sequencer FSM state encoding
//   SETTLE_W      - width of the settle counter and settle setting
//   SETTLE_MIN    - smallest settle time ever used (a setting of 0 becomes 1)
//   clamp_settle  - applies SETTLE_MIN to a requested settle time
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_e;

    localparam int unsigned SETTLE_W   = 32;
    localparam int unsigned SETTLE_MIN = 1;

    // A settle time of zero would never expire, so clamp it up to one cycle.
    function automatic logic [SETTLE_W-1:0] clamp_settle(input logic [SETTLE_W-1:0] value);
        return (value < SETTLE_W'(SETTLE_MIN)) ? SETTLE_W'(SETTLE_MIN) : value;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable 32-bit down-counter that times the DAC settling window for each bit.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clr_i          - force the count to zero (highest priority)
//   load_i         - load value_i
//   value_i        - reload value
//   dec_i          - count down by one; the count saturates at zero
//   expire_c_o     - combinational: count is 1, so this is the last settle cycle
module settle_timer
    import sar_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] value_i,
    input  logic                dec_i,
    output logic                expire_c_o
);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    // Next count: clear beats load, load beats decrement.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_c_o = (count_q == SETTLE_W'(1));

endmodule

// File: rtl/sar_sequencer.sv
// Successive-approximation sequencer driving a PWM DAC and reading back a comparator.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_start        - start a conversion (accepted only when idle)
//   i_abort        - cancel any conversion and return to idle; wins over i_start
//   i_settle       - cycles per bit for DAC settling, captured at start (0 acts as 1)
//   i_cmp          - comparator, 1 = DAC level above the input
//   o_dac_code     - trial code driven to the DAC (0 while idle)
//   o_busy         - high whenever a conversion is in progress or completing
//   o_done         - one-cycle completion pulse
//   o_result       - last completed conversion, held until the next completion
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [31:0]      i_settle,
    input  logic             i_cmp,
    output logic [WIDTH-1:0] o_dac_code,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned     IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] MSB_IDX  = IDX_W'(WIDTH - 1);

    sar_state_e          state_q,  state_d;
    logic [WIDTH-1:0]    dac_q,    dac_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic                tmr_clr;
    logic                tmr_load;
    logic                tmr_dec;
    logic [SETTLE_W-1:0] tmr_val;
    logic                tmr_expire;
    logic [SETTLE_W-1:0] settle_clamped;
    logic [WIDTH-1:0]    bit_mask;

    assign settle_clamped = clamp_settle(i_settle);
    assign bit_mask       = WIDTH'(1) << idx_q;

    settle_timer u_settle_timer (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .value_i    (tmr_val),
        .dec_i      (tmr_dec),
        .expire_c_o (tmr_expire)
    );

    // Next-state, SAR register and timer control.
    always_comb begin
        state_d  = state_q;
        dac_d    = dac_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        result_d = result_q;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = settle_q;

        if (i_abort) begin
            state_d = ST_IDLE;
            dac_d   = '0;
            idx_d   = '0;
            tmr_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d  = ST_SETTLE;
                        dac_d    = MSB_CODE;
                        idx_d    = MSB_IDX;
                        settle_d = settle_clamped;
                        tmr_load = 1'b1;
                        tmr_val  = settle_clamped;
                    end
                end
                ST_SETTLE: begin
                    tmr_dec = 1'b1;
                    if (tmr_expire) begin
                        state_d = ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    // Comparator high means the trial overshot: drop the current bit.
                    dac_d = i_cmp ? (dac_q & ~bit_mask) : dac_q;
                    if (idx_q != '0) begin
                        dac_d    = dac_d | (bit_mask >> 1);
                        idx_d    = idx_q - IDX_W'(1);
                        tmr_load = 1'b1;
                        state_d  = ST_SETTLE;
                    end else begin
                        result_d = dac_d;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    dac_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    dac_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            dac_q    <= '0;
            idx_q    <= '0;
            settle_q <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dac_q    <= dac_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign o_dac_code = dac_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_result   = result_q;

endmodule

// File: tb/tb_sar_sequencer.sv
// Scoreboard bench for sar_sequencer (WIDTH=8) with a behavioural comparator.
module tb_sar_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] settle = 32'd4;
    logic        cmp;
    logic [7:0]  dac;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic [7:0]  model_in = 8'h00;

    typedef struct {
        logic [7:0] res;
        int         start_cyc;
        int         lat;
        int         busy_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   done_base = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Comparator: DAC level above the analogue input.
    assign cmp = (dac > model_in);

    sar_sequencer #(.WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort),
        .i_settle   (settle),
        .i_cmp      (cmp),
        .o_dac_code (dac),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every o_done pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_single_cycle", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with result %0h, expected no done", result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", 32'(result), 32'(mon_e.res));
                    chk("dac_in_done", 32'(dac), 32'(mon_e.res));
                    chk("latency", 32'(cyc - mon_e.start_cyc + 1), 32'(mon_e.lat));
                    chk("busy_cycles", 32'(busy_run), 32'(mon_e.busy_cyc));
                    chk("busy_in_done", 32'(busy), 32'd1);
                end
                done_seen++;
            end
            if (busy && !done) busy_run++;
            else if (!busy) busy_run = 0;
            prev_done = done;
        end
    end

    // Start a conversion without expecting completion (for abort/reset cases).
    task automatic start_only(input logic [7:0] m, input logic [31:0] s);
        @(negedge clk);
        model_in = m;
        settle   = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [7:0] m, input logic [31:0] s, input logic [7:0] exp_res,
                         input int exp_lat, input int exp_busy);
        exp_t e;
        start_only(m, s);
        e.res       = exp_res;
        e.start_cyc = cyc;
        e.lat       = exp_lat;
        e.busy_cyc  = exp_busy;
        sb.push_back(e);
        done_base = done_seen;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_dac", 32'(dac), 32'h80);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && done_seen == done_base; i++) @(posedge clk);
        if (done_seen == done_base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done within 300 cycles");
        end else begin
            @(negedge clk);
            chk("idle_dac", 32'(dac), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #12;
        chk("rst_dac", 32'(dac), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        #10;
        rst_n = 1'b1;

        // Basic conversions and extremes.
        issue(8'h5A, 32'd4, 8'h5A, 41, 40); wait_done();
        issue(8'hFF, 32'd4, 8'hFF, 41, 40); wait_done();
        issue(8'h00, 32'd4, 8'h00, 41, 40); wait_done();
        // Settle of zero behaves as one cycle per bit.
        issue(8'h81, 32'd0, 8'h81, 17, 16); wait_done();

        // Abort during bit-3 settling; 0x33 gives upper bits 0011 and trial bit 3.
        issue(8'h5A, 32'd4, 8'h5A, 41, 40); wait_done();
        done_base = done_seen;
        start_only(8'h33, 32'd4);
        repeat (21) @(posedge clk);
        @(negedge clk);
        chk("bit3_trial", 32'(dac), 32'h38);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dac", 32'(dac), 32'd0);
        chk("abort_result", 32'(result), 32'h5A);
        repeat (60) @(posedge clk);
        chk("abort_no_done", 32'(done_seen), 32'(done_base));

        // Abort wins over a simultaneous start.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_over_start_busy", 32'(busy), 32'd0);
        chk("abort_over_start_dac", 32'(dac), 32'd0);

        // Restart and settle change while busy are ignored.
        issue(8'hA7, 32'd4, 8'hA7, 41, 40);
        repeat (10) @(posedge clk);
        @(negedge clk);
        settle = 32'd9;
        start  = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done();
        settle = 32'd4;

        // Asynchronous reset in the first DECIDE cycle.
        start_only(8'hC3, 32'd4);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dac", 32'(dac), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(8'hC3, 32'd4, 8'hC3, 41, 40); wait_done();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sar_sequencer.md
SAR_SEQUENCER -- requirements
Module: sar_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning number of SAR bits (legal 2..16).
REQ-002 SHALL have port i_clk  input  1  meaning single system clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  meaning asynchronous active-low reset.
REQ-004 SHALL have port i_start  input  1  meaning conversion request, sampled in IDLE only.
REQ-005 SHALL have port i_abort  input  1  meaning cancel conversion, return to IDLE.
REQ-006 SHALL have port i_settle  input  32  meaning clock cycles per bit for PWM-filter settling, sampled at start.
REQ-007 SHALL have port i_cmp  input  1  meaning comparator, 1 = DAC level above input; pre-synchronised externally.
REQ-008 SHALL have port o_dac_code  output  WIDTH  meaning trial code driven to PWM DAC.
REQ-009 SHALL have port o_busy  output  1  meaning high in every non-IDLE state.
REQ-010 SHALL have port o_done  output  1  meaning single-cycle pulse on conversion completion.
REQ-011 SHALL have port o_result  output  WIDTH  meaning last completed conversion result, held until the next completion.

Function
REQ-012 SHALL implement states IDLE, SETTLE, DECIDE, DONE.
REQ-013 IDLE with i_start=1 and i_abort=0: next cycle SHALL be SETTLE, bit index = WIDTH-1, o_dac_code = 1<<(WIDTH-1), settle counter loaded with max(i_settle,1).
REQ-014 SETTLE: counter SHALL decrement once per cycle; on the cycle counter==1, next state SHALL be DECIDE; SETTLE therefore lasts exactly max(i_settle,1) cycles.
REQ-015 DECIDE (one cycle): i_cmp=1 SHALL clear the current bit of o_dac_code; i_cmp=0 SHALL keep it.
REQ-016 DECIDE with index>0: SHALL decrement index, set the new current bit, reload the counter with the latched settle value, and go to SETTLE.
REQ-017 DECIDE with index==0: SHALL go to DONE.
REQ-018 DONE (one cycle): o_done SHALL be 1, o_result SHALL be loaded with o_dac_code, next state SHALL be IDLE.
REQ-019 Latency from the i_start sampling edge to the o_done-high cycle SHALL be WIDTH*(max(i_settle,1)+1)+1 cycles.
REQ-020 i_start outside IDLE SHALL be ignored (no queuing).
REQ-021 i_abort=1 in any state SHALL force IDLE on the next edge, clear o_dac_code to 0, suppress o_done, and leave o_result unchanged; abort SHALL win over simultaneous i_start.
REQ-022 i_settle changes during a conversion SHALL have no effect; the value latched at start SHALL be used.
REQ-023 o_dac_code SHALL be 0 in IDLE and SHALL retain the final code only during DONE.
REQ-024 The counter SHALL be 32-bit unsigned with no wrap; reload SHALL occur only from SETTLE entry.

Reset
REQ-025 Asserting i_rst_n=0 SHALL immediately force IDLE, o_dac_code=0, o_busy=0, o_done=0, o_result=0, counter=0, and index=0, including mid-conversion.
REQ-026 After reset release, the first i_start SHALL be accepted on the first clock edge.

Structure
REQ-027 Package sar_pkg SHALL hold the state enum typedef and constant SETTLE_MIN=1.
REQ-028 Settle timing SHALL be one sub-module, settle_timer (32-bit loadable down-counter with expiry flag); the FSM and SAR register SHALL stay in sar_sequencer.

Verification
REQ-029 WIDTH=8, i_settle=4, comparator model i_cmp=(o_dac_code>0x5A): start -> o_result=0x5A, o_done exactly 41 cycles after the start edge, o_busy high 40 cycles.
REQ-030 Model input 0xFF -> 0xFF; model input 0x00 -> 0x00; o_done each a single cycle.
REQ-031 i_settle=0 -> treated as 1; done 17 cycles after start; result correct for input 0x81.
REQ-032 i_abort pulsed during bit 3 SETTLE -> IDLE next cycle, o_dac_code=0, no o_done, o_result retains the previous 0x5A.
REQ-033 i_start reasserted while busy and i_settle changed to 9 mid-conversion -> ignored; latency remains 41 cycles.
REQ-034 i_rst_n low mid-DECIDE -> all outputs 0 asynchronously; a fresh conversion after release completes correctly.
